// File: rtl/mov_fsm_param_if.sv
// Bus-control bundle between the MOV sequencer and the datapath.
// master drives opcode/operands; slave (the sequencer) drives enables.
interface mov_fsm_param_if #(
    parameter int DATA_W = 16,
    parameter int OPND_W = 6
);
    logic [3:0]        FSM_start;
    logic [OPND_W-1:0] source;
    logic [OPND_W-1:0] dest;
    logic [OPND_W-1:0] register_rd_addr;
    logic [OPND_W-1:0] register_wr_addr;
    logic              bus_register_out_en;
    logic              bus_register_input_en;
    logic              I0_bus_output_en;
    logic              I0_bus_input_en;
    logic              I1_bus_output_en;
    logic              imm_bus_en;
    logic [DATA_W-1:0] imm_bus_data;
    logic              busy;
    logic              done;
    logic              error;

    modport master (
        output FSM_start, source, dest,
        input  register_rd_addr, register_wr_addr,
        input  bus_register_out_en, bus_register_input_en,
        input  I0_bus_output_en, I0_bus_input_en,
        input  I1_bus_output_en, imm_bus_en, imm_bus_data,
        input  busy, done, error
    );

    modport slave (
        input  FSM_start, source, dest,
        output register_rd_addr, register_wr_addr,
        output bus_register_out_en, bus_register_input_en,
        output I0_bus_output_en, I0_bus_input_en,
        output I1_bus_output_en, imm_bus_en, imm_bus_data,
        output busy, done, error
    );
endinterface

// File: rtl/mov_fsm_param.sv
// MOV / immediate-MOV sequencer for the single-bus datapath.
// Define SIGN_EXT_EN to sign-extend immediates (default: zero-extend).
module mov_fsm_param #(
    parameter int         DATA_W    = 16,
    parameter int         OPND_W    = 6,
    parameter int         NUM_REGS  = 5,
    parameter logic [3:0] START_MOV = 4'b0111,
    parameter logic [3:0] START_IMM = 4'b1000
) (
    input logic            clock,
    input logic            reset,
    mov_fsm_param_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, LOAD, DRIVE, WRITE, RELEASE, DONE
    } state_t;

    localparam logic [OPND_W-1:0] CODE_I0 = OPND_W'(NUM_REGS);
    localparam logic [OPND_W-1:0] CODE_I1 = OPND_W'(NUM_REGS + 1);

    state_t            state, state_nx;
    logic [OPND_W-1:0] src_q, dst_q;
    logic              imm_q;
    logic              start_hit, accept;

    logic src_is_reg, src_is_i0, src_is_i1, src_bad;
    logic dst_is_reg, dst_is_i0, dst_bad;

    logic src_reg_q, src_i0_q, src_i1_q, src_imm_q;
    logic dst_reg_q, dst_i0_q, err_q;

    logic [OPND_W-1:0] rd_addr_q, wr_addr_q;
    logic [DATA_W-1:0] imm_data_q, imm_ext;
    logic              fill;
    logic              src_phase, dst_phase;

    assign start_hit = (bus.FSM_start == START_MOV)
                    || (bus.FSM_start == START_IMM);
    // DONE also accepts so back-to-back ops are 5 cycles apart
    assign accept = start_hit && (state == IDLE || state == DONE);

    assign src_is_reg = !imm_q && (src_q < CODE_I0);
    assign src_is_i0  = !imm_q && (src_q == CODE_I0);
    assign src_is_i1  = !imm_q && (src_q == CODE_I1);
    assign src_bad    = !imm_q && (src_q > CODE_I1);
    assign dst_is_reg = dst_q < CODE_I0;
    assign dst_is_i0  = dst_q == CODE_I0;
    assign dst_bad    = dst_q > CODE_I0;

`ifdef SIGN_EXT_EN
    assign fill = src_q[OPND_W-1];
`else
    assign fill = 1'b0;
`endif

    for (genvar i = 0; i < DATA_W; i++) begin : g_ext
        if (i < OPND_W) begin : g_src
            assign imm_ext[i] = src_q[i];
        end else begin : g_fill
            assign imm_ext[i] = fill;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            src_q      <= '0;
            dst_q      <= '0;
            imm_q      <= 1'b0;
            src_reg_q  <= 1'b0;
            src_i0_q   <= 1'b0;
            src_i1_q   <= 1'b0;
            src_imm_q  <= 1'b0;
            dst_reg_q  <= 1'b0;
            dst_i0_q   <= 1'b0;
            err_q      <= 1'b0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            imm_data_q <= '0;
        end else begin
            if (accept) begin
                src_q <= bus.source;
                dst_q <= bus.dest;
                imm_q <= (bus.FSM_start == START_IMM);
            end
            if (state == LOAD) begin
                src_reg_q <= src_is_reg;
                src_i0_q  <= src_is_i0;
                src_i1_q  <= src_is_i1;
                src_imm_q <= imm_q;
                // a bad source suppresses the write as well
                dst_reg_q <= dst_is_reg && !src_bad;
                dst_i0_q  <= dst_is_i0 && !src_bad;
                err_q     <= src_bad || dst_bad;
                if (src_is_reg) rd_addr_q <= src_q;
                if (dst_is_reg) wr_addr_q <= dst_q;
                imm_data_q <= imm_q ? imm_ext : '0;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        src_phase = 1'b0;
        dst_phase = 1'b0;
        unique case (state)
            IDLE:    if (start_hit) state_nx = LOAD;
            LOAD:    state_nx = DRIVE;
            DRIVE: begin
                state_nx  = WRITE;
                src_phase = 1'b1;
            end
            WRITE: begin
                state_nx  = RELEASE;
                src_phase = 1'b1;
                dst_phase = 1'b1;
            end
            RELEASE: state_nx = DONE;
            DONE:    state_nx = start_hit ? LOAD : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.bus_register_out_en   = src_phase && src_reg_q;
        bus.I0_bus_output_en      = src_phase && src_i0_q;
        bus.I1_bus_output_en      = src_phase && src_i1_q;
        bus.imm_bus_en            = src_phase && src_imm_q;
        bus.bus_register_input_en = dst_phase && dst_reg_q;
        bus.I0_bus_input_en       = dst_phase && dst_i0_q;
        bus.busy                  = state != IDLE;
        bus.done                  = state == DONE;
        bus.error                 = (state == DONE) && err_q;
    end

    assign bus.register_rd_addr = rd_addr_q;
    assign bus.register_wr_addr = wr_addr_q;
    assign bus.imm_bus_data     = imm_data_q;

    a_bus_excl: assert property (
        @(posedge clock) disable iff (reset)
        $onehot0({bus.bus_register_out_en, bus.I0_bus_output_en,
                  bus.I1_bus_output_en, bus.imm_bus_en})
    );
endmodule

// File: tb/tb_mov_fsm_param.sv
// Directed bench for mov_fsm_param: per-cycle enable windows,
// illegal operands, start-while-busy and asynchronous reset.
module tb_mov_fsm_param;
    localparam logic [3:0] S_MOV = 4'b0111;
    localparam logic [3:0] S_IMM = 4'b1000;
`ifdef SIGN_EXT_EN
    localparam int IMM_2A = 32'hFFEA;
    localparam int IMM_3F = 32'hFFFF;
`else
    localparam int IMM_2A = 32'h002A;
    localparam int IMM_3F = 32'h003F;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    mov_fsm_param_if #(.DATA_W(16), .OPND_W(6)) b ();

    mov_fsm_param dut (
        .clock(clock),
        .reset(reset),
        .bus  (b)
    );

    always #5 clock = ~clock;

    logic [3:0] src_en;
    logic [1:0] dst_en;
    assign src_en = {b.bus_register_out_en, b.I0_bus_output_en,
                     b.I1_bus_output_en, b.imm_bus_en};
    assign dst_en = {b.bus_register_input_en, b.I0_bus_input_en};

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_op(input logic [3:0] st,
                          input logic [5:0] s,
                          input logic [5:0] d,
                          input logic [3:0] e_src,
                          input logic [1:0] e_dst,
                          input int e_rd,
                          input int e_wr,
                          input int e_imm,
                          input logic e_err);
        b.FSM_start = st;
        b.source    = s;
        b.dest      = d;
        tick();
        b.FSM_start = 4'h0;
        b.source    = ~s;
        b.dest      = ~d;
        chk("load_busy", 32'(b.busy), 32'd1);
        chk("load_src", 32'(src_en), 32'd0);
        tick();
        chk("drive_src", 32'(src_en), 32'(e_src));
        chk("drive_dst", 32'(dst_en), 32'd0);
        if (e_rd >= 0) chk("rd_addr", 32'(b.register_rd_addr), e_rd);
        if (e_wr >= 0) chk("wr_addr", 32'(b.register_wr_addr), e_wr);
        if (e_imm >= 0) chk("imm_data", 32'(b.imm_bus_data), e_imm);
        tick();
        chk("write_src", 32'(src_en), 32'(e_src));
        chk("write_dst", 32'(dst_en), 32'(e_dst));
        tick();
        chk("rel_en", 32'({src_en, dst_en}), 32'd0);
        chk("rel_done", 32'(b.done), 32'd0);
        tick();
        chk("done", 32'(b.done), 32'd1);
        chk("error", 32'(b.error), 32'(e_err));
        chk("done_busy", 32'(b.busy), 32'd1);
        tick();
        chk("idle_busy", 32'(b.busy), 32'd0);
        chk("idle_done", 32'(b.done), 32'd0);
    endtask

    initial begin
        int ndone;
        int first_done;
        int second_done;
        b.FSM_start = 4'h0;
        b.source    = '0;
        b.dest      = '0;
        tick();
        chk("rst_busy", 32'(b.busy), 32'd0);
        chk("rst_en", 32'({src_en, dst_en}), 32'd0);
        chk("rst_rd", 32'(b.register_rd_addr), 32'd0);
        chk("rst_imm", 32'(b.imm_bus_data), 32'd0);
        reset = 1'b0;
        tick();

        run_op(S_MOV, 6'd2, 6'd4, 4'b1000, 2'b10, 2, 4, -1, 1'b0);
        run_op(S_IMM, 6'b101010, 6'd5, 4'b0001, 2'b01, -1, 4, IMM_2A, 1'b0);
        run_op(S_MOV, 6'd6, 6'd1, 4'b0010, 2'b10, 2, 1, -1, 1'b0);
        run_op(S_MOV, 6'd6, 6'd6, 4'b0010, 2'b00, 2, 1, -1, 1'b1);
        run_op(S_MOV, 6'd5, 6'd3, 4'b0100, 2'b10, 2, 3, -1, 1'b0);
        run_op(S_MOV, 6'd9, 6'd2, 4'b0000, 2'b00, 2, 2, -1, 1'b1);
        run_op(S_MOV, 6'd3, 6'd3, 4'b1000, 2'b10, 3, 3, -1, 1'b0);
        run_op(S_IMM, 6'd63, 6'd0, 4'b0001, 2'b10, 3, 0, IMM_3F, 1'b0);

        b.FSM_start = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("nostart_busy", 32'(b.busy), 32'd0);
        end

        ndone       = 0;
        first_done  = -1;
        second_done = -1;
        b.source    = 6'd1;
        b.dest      = 6'd2;
        for (int i = 0; i < 14; i++) begin
            b.FSM_start = (i < 10) ? S_MOV : 4'h0;
            tick();
            if (i == 0) begin
                b.source = 6'd3;
                b.dest   = 6'd4;
            end
            if (i == 2) chk("hold_rd1", 32'(b.register_rd_addr), 32'd1);
            if (i == 2) chk("hold_wr1", 32'(b.register_wr_addr), 32'd2);
            if (i == 7) chk("hold_rd2", 32'(b.register_rd_addr), 32'd3);
            if (b.done) begin
                ndone++;
                if (first_done < 0) first_done = i;
                else second_done = i;
            end
        end
        chk("hold_ndone", 32'(ndone), 32'd2);
        chk("hold_first", 32'(first_done), 32'd4);
        chk("hold_gap", 32'(second_done - first_done), 32'd5);

        b.FSM_start = S_MOV;
        b.source    = 6'd2;
        b.dest      = 6'd4;
        tick();
        b.FSM_start = 4'h0;
        tick();
        tick();
        chk("pre_rst_dst", 32'(dst_en), 32'd2);
        #2 reset = 1'b1;
        #1;
        chk("arst_en", 32'({src_en, dst_en}), 32'd0);
        chk("arst_busy", 32'(b.busy), 32'd0);
        chk("arst_done", 32'(b.done), 32'd0);
        chk("arst_wr", 32'(b.register_wr_addr), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_busy", 32'(b.busy), 32'd0);
        run_op(S_MOV, 6'd1, 6'd0, 4'b1000, 2'b10, 1, 0, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
